not_pipe: RTL and testbench
===========================

# not_pipe

Parametrised, pipelined bitwise inverter. Each accepted beat is inverted bit-by-bit under a per-beat mask, then carried through a configurable number of register stages with valid/ready flow control. It generalises the single-bit NOT primitive to WIDTH bits with selectable inversion, and sits between a producer and a consumer on the datapath as an elastic, full-throughput stage.

## Interface
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 2, number of register stages, equal to both the latency and the capacity in beats (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer presents a beat
- in_ready  output  1  block accepts a beat this cycle
- in_data  input  WIDTH  operand
- in_mask  input  WIDTH  inversion mask: bit 1 = invert, bit 0 = pass through
- out_valid  output  1  out_data holds a valid result
- out_ready  input  1  consumer takes the result this cycle
- out_data  output  WIDTH  result
- busy  output  1  at least one stage holds a valid beat

## Operation
- Result function: result = in_data XOR in_mask, computed on entry to stage 0.
  - Mask all ones gives a full NOT.
  - Mask zero gives a pass-through.
- Stage i register pair is v[i] (valid) and d[i] (data).
  - Stage 0 is the entry stage.
  - Stage DEPTH-1 drives out_valid and out_data.
- Stage i is free when v[i]=0 or stage i advances this cycle.
  - For i<DEPTH-1, stage i advances when v[i]=1 and stage i+1 is free.
  - The last stage advances when out_valid and out_ready are both 1.
- Ready chain:
  - in_ready = stage 0 free.
  - The chain is combinational from out_ready back to in_ready, with no bubble cycle.
- Accept happens when in_valid and in_ready are both 1. On accept, d[0] loads the result and v[0] is set.
- When stage i is free and nothing enters it, v[i] clears. d[i] holds its old value.
- busy = OR of all v[i].
- Stages are never overwritten while valid and not advancing. Beats are never dropped or duplicated, and order is preserved.

## Timing
- Reset (rst_n=0, asynchronous):
  - All v[i]=0 and all d[i]=0.
  - Outputs: out_valid=0, out_data=0, busy=0, in_ready=1.
  - Effect is immediate, without waiting for a clock edge.
- Reset release: the block operates normally from the first rising clk edge with rst_n=1.
- Reset asserted mid-operation discards every in-flight beat, and no partial output occurs. If a beat was being handed over in the same cycle, its out_valid still drops immediately.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+DEPTH-1. Count it as DEPTH cycles from in_valid sampled to out_valid observed, when unstalled.
- Throughput: one beat per cycle while out_ready=1.
- Capacity: DEPTH beats.
  - When all stages are valid and out_ready=0, in_ready=0.
  - When all stages are valid and out_ready=1, in_ready=1 in the same cycle. Accept and drain happen simultaneously.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold constant.
- Input values are ignored when in_valid=0. d[0] is not loaded on those cycles.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle with the pipeline holding 2 beats.
  - Required: out_valid=0, out_data=0x0000, busy=0 and in_ready=1 immediately, before the next clk edge. After release, no stale beat emerges.
- Single beat (WIDTH=16, DEPTH=2):
  - Stimulus: in_data=0x00FF, in_mask=0xFFFF, out_ready=1.
  - Required: out_valid=1 with out_data=0xFF00 exactly 2 cycles after acceptance, held for 1 cycle.
- Masked inversion:
  - Stimulus: in_data=0xA5A5 with mask=0x0F0F, then in_data=0x1234 with mask=0x0000.
  - Required: outputs 0xAAAA then 0x1234, in order.
- Streaming:
  - Stimulus: 8 back-to-back beats 0x0000..0x0007 with mask 0xFFFF and out_ready=1 constantly.
  - Required: in_ready stays 1. Outputs are 0xFFFF..0xFFF8 on 8 consecutive cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 and offer 3 beats.
  - Required: only 2 are accepted. in_ready=0 afterwards, and out_data is stable.
  - Then raise out_ready for 1 cycle with the third beat still offered. Required: one beat drains and the third is accepted in that same cycle, with no loss or reordering.
- Parameter sweep:
  - Stimulus: WIDTH=1, DEPTH=1, random valid/ready traffic against a reference queue model.
  - Required: every output equals the corresponding in_data XOR in_mask, in order, with latency 1 when unstalled.

Source files
------------

// File: rtl/not_pipe.sv
// Elastic pipelined bitwise inverter: each beat becomes in_data ^ in_mask on entry,
// then moves through DEPTH valid/data register stages with full-throughput flow control.
module not_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a presented output holds until it transfers.

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] free;
    logic [WIDTH-1:0] d [DEPTH];

    // Stage i is free unless it and every stage after it are full while out_ready is low,
    // which makes the ready chain combinational from out_ready without a bubble.
    always_comb begin
        logic all_v;
        all_v = 1'b1;
        free  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_v   = all_v & v[i];
            free[i] = out_ready | ~all_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            if (free[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= in_data ^ in_mask;
                end
            end
            // Data registers only load when a valid beat enters, so idle stages keep old data.
            for (int i = 1; i < DEPTH; i++) begin
                if (free[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = free[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign busy      = |v;

endmodule

// File: tb/tb_not_pipe.sv
// Bench for not_pipe: a 16-bit/2-stage instance driven from a vector table and
// hand-written corner sequences, plus a 1-bit/1-stage instance under random traffic.
module tb_not_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_in_data, a_in_mask, a_out_data, a_cur_exp;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [0:0]  b_in_data, b_in_mask, b_out_data;

    not_pipe #(.WIDTH(16), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mask(a_in_mask),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    not_pipe #(.WIDTH(1), .DEPTH(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mask(b_in_mask),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] mask;
        logic [15:0] exp;
    } vec_t;

    vec_t vec [14];

    logic [15:0] exp_q [$];
    logic [0:0]  b_q [$];
    int          out_cyc_q [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        b_acc_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int i);
        a_in_valid = 1'b1;
        a_in_data  = vec[i].data;
        a_in_mask  = vec[i].mask;
        a_cur_exp  = vec[i].exp;
    endtask

    // Scoreboard for instance A: push on accept, pop and compare on handover.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_in_valid && a_in_ready) exp_q.push_back(a_cur_exp);
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("a_unexpected_out", {31'b0, a_out_valid}, 32'd0);
                end else begin
                    check("a_out_data", {16'b0, a_out_data}, {16'b0, exp_q.pop_front()});
                    out_cyc_q.push_back(cyc);
                end
            end
        end
    end

    // Scoreboard for instance B with a reference XOR model and a latency-1 check.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_acc_prev) check("b_latency", {31'b0, b_out_valid}, 32'd1);
            if (b_in_valid && b_in_ready) b_q.push_back(b_in_data ^ b_in_mask);
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected_out", {31'b0, b_out_valid}, 32'd0);
                end else begin
                    check("b_out_data", {31'b0, b_out_data}, {31'b0, b_q.pop_front()});
                end
            end
            b_acc_prev <= b_in_valid && b_in_ready;
        end else begin
            b_acc_prev <= 1'b0;
        end
    end

    initial begin
        int span;
        vec[0]  = '{16'h00FF, 16'hFFFF, 16'hFF00};
        vec[1]  = '{16'hA5A5, 16'h0F0F, 16'hAAAA};
        vec[2]  = '{16'h1234, 16'h0000, 16'h1234};
        vec[3]  = '{16'h0000, 16'hFFFF, 16'hFFFF};
        vec[4]  = '{16'h0001, 16'hFFFF, 16'hFFFE};
        vec[5]  = '{16'h0002, 16'hFFFF, 16'hFFFD};
        vec[6]  = '{16'h0003, 16'hFFFF, 16'hFFFC};
        vec[7]  = '{16'h0004, 16'hFFFF, 16'hFFFB};
        vec[8]  = '{16'h0005, 16'hFFFF, 16'hFFFA};
        vec[9]  = '{16'h0006, 16'hFFFF, 16'hFFF9};
        vec[10] = '{16'h0007, 16'hFFFF, 16'hFFF8};
        vec[11] = '{16'h1111, 16'hFFFF, 16'hEEEE};
        vec[12] = '{16'h2222, 16'hFFFF, 16'hDDDD};
        vec[13] = '{16'h3333, 16'hFFFF, 16'hCCCC};

        a_in_valid = 0; a_in_data = 0; a_in_mask = 0; a_cur_exp = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_mask = 0; b_out_ready = 0;

        // Reset state
        #2;
        check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
        check("rst_out_data", {16'b0, a_out_data}, 32'd0);
        check("rst_busy", {31'b0, a_busy}, 32'd0);
        check("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
        check("rst_b_in_ready", {31'b0, b_in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single beat: visible after the second edge, held for one cycle
        a_out_ready = 1'b1;
        drive_a(0);
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("single_early", {31'b0, a_out_valid}, 32'd0);
        @(negedge clk);
        check("single_valid", {31'b0, a_out_valid}, 32'd1);
        check("single_data", {16'b0, a_out_data}, 32'h0000FF00);
        @(negedge clk);
        check("single_gone", {31'b0, a_out_valid}, 32'd0);
        tick();

        // Masked inversion, order checked by the scoreboard
        drive_a(1);
        tick();
        drive_a(2);
        tick();
        a_in_valid = 1'b0;
        repeat (4) tick();
        check("masked_drained", 32'(exp_q.size()), 32'd0);

        // Streaming 8 back-to-back beats
        out_cyc_q.delete();
        for (int k = 3; k <= 10; k++) begin
            drive_a(k);
            @(negedge clk);
            check("stream_in_ready", {31'b0, a_in_ready}, 32'd1);
            tick();
        end
        a_in_valid = 1'b0;
        repeat (4) tick();
        check("stream_count", 32'(out_cyc_q.size()), 32'd8);
        span = (out_cyc_q.size() >= 8) ? out_cyc_q[7] - out_cyc_q[0] : -1;
        check("stream_consecutive", 32'(span), 32'd7);

        // Backpressure: two fit, the third waits, then drain and accept together
        a_out_ready = 1'b0;
        drive_a(11);
        tick();
        drive_a(12);
        tick();
        drive_a(13);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", {31'b0, a_in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, a_out_valid}, 32'd1);
            check("bp_out_stable", {16'b0, a_out_data}, 32'h0000EEEE);
            tick();
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        check("bp_same_cycle_ready", {31'b0, a_in_ready}, 32'd1);
        tick();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        @(negedge clk);
        check("bp_next_data", {16'b0, a_out_data}, 32'h0000DDDD);
        check("bp_full_again", {31'b0, a_in_ready}, 32'd0);
        tick();
        a_out_ready = 1'b1;
        repeat (4) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_idle", {31'b0, a_busy}, 32'd0);

        // Asynchronous reset mid-cycle with two beats in flight
        a_out_ready = 1'b0;
        drive_a(1);
        tick();
        drive_a(2);
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {31'b0, a_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, a_out_valid}, 32'd0);
        check("mid_rst_out_data", {16'b0, a_out_data}, 32'd0);
        check("mid_rst_busy", {31'b0, a_busy}, 32'd0);
        check("mid_rst_in_ready", {31'b0, a_in_ready}, 32'd1);
        exp_q.delete();
        b_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        repeat (5) tick();
        check("post_rst_no_stale", {31'b0, a_out_valid}, 32'd0);
        check("post_rst_busy", {31'b0, a_busy}, 32'd0);

        // WIDTH=1, DEPTH=1 random traffic
        for (int k = 0; k < 300; k++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = 1'($urandom_range(0, 1));
            b_in_mask   = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) tick();
        check("b_drained", 32'(b_q.size()), 32'd0);
        check("b_idle", {31'b0, b_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
